bfs_spill_ctrl: RTL and testbench



---
 rtl/bfs_spill_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bfs_spill_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfs_spill_ctrl.sv
// Spill/restore engine: packs 8x64b queue beats into 512b ring lines and streams them back FIFO order (stats: BFS_SPILL_STATS_EN).
// Latency: 8 beat cycles plus memory grant/read wait; holds dc_ready low and mem_req high until the memory responds.
module bfs_spill_ctrl #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned       RING_LINES = 256
) (
  input  logic              clk,
  input  logic              bfs_rst_n,
  input  logic              spill_req,
  input  logic              spill_op,
  input  logic [63:0]       spill_data,
  output logic              dc_ready,
  output logic              dc_fs,
  output logic [1:0]        dc_op,
  output logic [63:0]       dc_rdata,
  output logic              dc_rbuf_empty,
  output logic              ring_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [511:0]      mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [511:0]      mem_rdata
`ifdef BFS_SPILL_STATS_EN
  ,
  output logic [31:0]                   stat_spills,
  output logic [31:0]                   stat_restores,
  output logic [$clog2(RING_LINES):0]   stat_max_lines
`endif
);

  localparam int unsigned PW = $clog2(RING_LINES);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {IDLE, S_FS, S_BEAT, S_WR, R_RD, R_WAIT, R_FS, R_BEAT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      beat_q;
  logic [511:0]    line_q;
  logic            rdy_q, drop_q, ovf_q, unf_q;
  logic            accept, full, empty, wr_done, rd_done;

  assign accept  = spill_req & rdy_q;
  assign full    = (count_q == CW'(RING_LINES));
  assign empty   = (count_q == '0);
  assign wr_done = (state_q == S_WR) & mem_gnt;
  assign rd_done = (state_q == R_RD) & mem_gnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = spill_op ? (empty ? R_FS : R_RD) : S_FS;
      S_FS:    state_d = S_BEAT;
      S_BEAT:  if (beat_q == 3'd7) state_d = drop_q ? IDLE : S_WR;
      S_WR:    if (mem_gnt) state_d = IDLE;
      R_RD:    if (mem_gnt) state_d = R_WAIT;
      R_WAIT:  if (mem_rvalid) state_d = R_FS;
      R_FS:    state_d = R_BEAT;
      R_BEAT:  if (beat_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge bfs_rst_n) begin
    if (!bfs_rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      beat_q  <= 3'd0;
      line_q  <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
      beat_q  <= (state_d == S_BEAT || state_d == R_BEAT) ? beat_q + 3'd1 : 3'd0;

      // A restore from an empty ring streams zeros, so the stale line is wiped at accept.
      if (state_q == S_FS || state_q == S_BEAT)
        line_q[{beat_q, 6'b0} +: 64] <= spill_data;
      else if (state_q == R_WAIT && mem_rvalid)
        line_q <= mem_rdata;
      else if (accept && spill_op && empty)
        line_q <= '0;

      if (accept) begin
        drop_q <= !spill_op && full;
        if (!spill_op && full) ovf_q <= 1'b1;
        if (spill_op && empty) unf_q <= 1'b1;
      end

      if (wr_done) begin
        tail_q  <= tail_q + 1'b1;
        count_q <= count_q + 1'b1;
      end else if (rd_done) begin
        head_q  <= head_q + 1'b1;
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    dc_ready      = rdy_q;
    dc_fs         = (state_q == S_FS) || (state_q == R_FS);
    dc_op         = 2'b00;
    dc_rdata      = '0;
    dc_rbuf_empty = (state_q == IDLE);
    ring_empty    = empty;
    overflow      = ovf_q;
    underflow     = unf_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    unique case (state_q)
      S_FS, S_BEAT: dc_op = 2'b01;
      R_FS, R_BEAT: begin
        dc_op    = 2'b11;
        dc_rdata = line_q[{beat_q, 6'b0} +: 64];
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + (ADDR_W'(tail_q) << 6);
        mem_wdata = line_q;
      end
      R_RD: begin
        mem_req  = 1'b1;
        mem_addr = BASE_ADDR + (ADDR_W'(head_q) << 6);
      end
      default: ;
    endcase
  end

`ifdef BFS_SPILL_STATS_EN
  always_ff @(posedge clk or negedge bfs_rst_n) begin
    if (!bfs_rst_n) begin
      stat_spills    <= '0;
      stat_restores  <= '0;
      stat_max_lines <= '0;
    end else begin
      if (wr_done && stat_spills != '1)
        stat_spills <= stat_spills + 32'd1;
      if (state_q == R_BEAT && beat_q == 3'd7 && stat_restores != '1)
        stat_restores <= stat_restores + 32'd1;
      if (count_q > stat_max_lines)
        stat_max_lines <= count_q;
    end
  end
`endif

endmodule

// File: tb/tb_bfs_spill_ctrl.sv
// Directed bench for bfs_spill_ctrl on a 2-line ring: queue/memory responders plus a line-level reference model.
module tb_bfs_spill_ctrl;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int unsigned RL     = 2;

  logic clk = 1'b0;
  logic bfs_rst_n = 1'b0;
  logic spill_req = 1'b0, spill_op = 1'b0;
  logic [63:0] spill_data = '0;
  logic dc_ready, dc_fs, dc_rbuf_empty, ring_empty, overflow, underflow;
  logic [1:0] dc_op;
  logic [63:0] dc_rdata;
  logic mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [511:0] mem_wdata;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [511:0] mem_rdata = '0;
`ifdef BFS_SPILL_STATS_EN
  logic [31:0] stat_spills, stat_restores;
  logic [$clog2(RL):0] stat_max_lines;
`endif

  bfs_spill_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RING_LINES(RL)) dut (
    .clk(clk), .bfs_rst_n(bfs_rst_n),
    .spill_req(spill_req), .spill_op(spill_op), .spill_data(spill_data),
    .dc_ready(dc_ready), .dc_fs(dc_fs), .dc_op(dc_op), .dc_rdata(dc_rdata),
    .dc_rbuf_empty(dc_rbuf_empty), .ring_empty(ring_empty),
    .overflow(overflow), .underflow(underflow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef BFS_SPILL_STATS_EN
    , .stat_spills(stat_spills), .stat_restores(stat_restores), .stat_max_lines(stat_max_lines)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: ring contents as a queue of whole lines plus expected bus events.
  typedef struct packed { logic [31:0] addr; logic [511:0] data; } wr_t;
  logic [511:0] ring_q[$];
  wr_t          exp_wr[$];
  logic [31:0]  exp_rd[$];
  logic [63:0]  exp_beats[$];
  logic [31:0]  wr_log[$];
  logic [511:0] mem [logic [31:0]];
  int   mhead = 0, mtail = 0;
  logic m_ovf = 1'b0, m_unf = 1'b0;
  bit   chk_en = 1'b0;
  int   st_idx = 0;

  logic [63:0] cur_line [8];
  int feed_idx = 0;
  int gnt_delay = 0, rv_delay = 0;
  bit junk_rv = 1'b0;

  initial begin : feeder
    forever begin
      @(posedge clk); #1;
      if (dc_op == 2'b01 && feed_idx < 8) begin
        spill_data = cur_line[feed_idx];
        feed_idx++;
      end
    end
  end

  initial begin : mem_model
    int wcnt = 0;
    bit rv_pend = 1'b0;
    int rv_cnt = 0;
    logic [511:0] rv_line = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (!bfs_rst_n) begin
        wcnt = 0; rv_pend = 1'b0;
      end else begin
        if (rv_pend) begin
          if (rv_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rv_line; rv_pend = 1'b0;
          end else rv_cnt--;
        end
        if (mem_req) begin
          if (wcnt >= gnt_delay) begin
            mem_gnt = 1'b1; wcnt = 0;
            if (mem_we) begin
              mem[mem_addr] = mem_wdata;
              wr_log.push_back(mem_addr);
            end else begin
              rv_pend = 1'b1; rv_cnt = rv_delay;
              rv_line = mem.exists(mem_addr) ? mem[mem_addr] : '0;
            end
          end else begin
            wcnt++;
            if (junk_rv && !mem_we) begin
              mem_rvalid = 1'b1; mem_rdata = {16{32'hDEAD_BEEF}};
            end
          end
        end else wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    wr_t w;
    if (chk_en && bfs_rst_n) begin
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
      if (dc_ready) begin
        chk("idle_ring_empty", ring_empty, ring_q.size() == 0);
        chk("idle_rbuf_empty", dc_rbuf_empty, 1'b1);
        chk("idle_mem_req", mem_req, 1'b0);
      end
      if (dc_op != 2'b00) begin
        chk("dc_fs_beat", dc_fs, st_idx == 0);
        st_idx++;
        if (dc_op == 2'b11) begin
          if (exp_beats.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_restore_beat: got %0h, no beat expected", dc_rdata);
          end else chk("dc_rdata", dc_rdata, exp_beats.pop_front());
        end else begin
          chk("dc_op_spill", dc_op, 2'b01);
          chk("spill_rdata_zero", dc_rdata, 64'h0);
          chk("spill_rbuf_busy", dc_rbuf_empty, 1'b0);
        end
      end else begin
        if (st_idx != 0) chk("stream_len", st_idx, 8);
        st_idx = 0;
        chk("dc_fs_quiet", dc_fs, 1'b0);
        chk("dc_rdata_quiet", dc_rdata, 64'h0);
      end
      if (mem_req) chk("mem_rbuf_busy", dc_rbuf_empty, 1'b0);
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0h, no write expected", mem_addr);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_wdata, w.data);
          end
        end else begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: addr %0h, no read expected", mem_addr);
          end else chk("rd_addr", mem_addr, exp_rd.pop_front());
        end
      end
    end else st_idx = 0;
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!dc_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!dc_ready) begin
      checks++; errors++;
      $display("FAIL %s_timeout: dc_ready 0 after %0d cycles, required 1", nm, n);
    end
  endtask

  task automatic load_line(input logic [63:0] b0, input logic [63:0] step, output logic [511:0] line);
    for (int i = 0; i < 8; i++) begin
      cur_line[i] = b0 + step * 64'(i);
      line[64*i +: 64] = cur_line[i];
    end
  endtask

  task automatic do_spill(input logic [63:0] b0, input logic [63:0] step);
    logic [511:0] line;
    wr_t w;
    load_line(b0, step, line);
    wait_ready("spill_start");
    feed_idx = 0;
    spill_req = 1'b1; spill_op = 1'b0;
    @(posedge clk); #1;
    spill_req = 1'b0;
    if (ring_q.size() == RL) m_ovf = 1'b1;
    else begin
      w.addr = BASE + 32'(mtail * 64); w.data = line;
      exp_wr.push_back(w);
      ring_q.push_back(line);
      mtail = (mtail + 1) % RL;
    end
    wait_ready("spill_done");
  endtask

  task automatic do_restore(output int ncyc);
    logic [511:0] line;
    int n;
    wait_ready("restore_start");
    spill_req = 1'b1; spill_op = 1'b1;
    @(posedge clk); #1;
    spill_req = 1'b0; spill_op = 1'b0; n = 1;
    if (ring_q.size() == 0) begin
      m_unf = 1'b1;
      for (int i = 0; i < 8; i++) exp_beats.push_back(64'h0);
    end else begin
      line = ring_q.pop_front();
      exp_rd.push_back(BASE + 32'(mhead * 64));
      mhead = (mhead + 1) % RL;
      for (int i = 0; i < 8; i++) exp_beats.push_back(line[64*i +: 64]);
    end
    while (!dc_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!dc_ready) begin
      checks++; errors++;
      $display("FAIL restore_timeout: dc_ready 0 after %0d cycles, required 1", n);
    end
    ncyc = n;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    logic [511:0] l;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dc_ready", dc_ready, 1'b0);
    chk("rst_ring_empty", ring_empty, 1'b1);
    chk("rst_rbuf_empty", dc_rbuf_empty, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_dc_op", dc_op, 2'b00);
    chk("rst_dc_fs", dc_fs, 1'b0);
    chk("rst_flags", {overflow, underflow, mem_we}, 3'b000);
    chk("rst_mem_addr", mem_addr, 32'h0);
    bfs_rst_n = 1'b1; #1;
    chk("release_ready_low", dc_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", dc_ready, 1'b1);
    chk_en = 1'b1;

    gnt_delay = 3;
    do_spill(64'h0, 64'h1);
    chk("wr0_addr", wr_log[0], 32'h1000_0000);
    l = mem[32'h1000_0000];
    chk("wr0_beat7", l[511:448], 64'h7);
    chk("wr0_beat0", l[63:0], 64'h0);
    chk("ring_not_empty", ring_empty, 1'b0);

    gnt_delay = 0;
    do_spill(64'hB000_0000_0000_0000, 64'h1111);
    chk("wr1_addr", wr_log[1], 32'h1000_0040);
    do_spill(64'hC0C0_0000_0000_0000, 64'h3);
    chk("overflow_set", overflow, 1'b1);
    chk("no_wr_when_full", wr_log.size(), 2);

    gnt_delay = 1; rv_delay = 2; junk_rv = 1'b1;
    do_restore(n);
    do_restore(n);
    junk_rv = 1'b0;
    chk("ring_empty_after_restores", ring_empty, 1'b1);

    gnt_delay = 2;
    do_spill(64'hD000_0000_0000_00D0, 64'h5);
    chk("wr2_wrap_addr", wr_log[2], 32'h1000_0000);
    gnt_delay = 0; rv_delay = 0;
    do_restore(n);
    do_restore(n);
    chk("underflow_set", underflow, 1'b1);
    chk("underflow_ready_cycles", n, 9);

    gnt_delay = 1000;
    load_line(64'hEEEE_0000_0000_0000, 64'h7, l);
    wait_ready("rst_spill_start");
    feed_idx = 0; spill_req = 1'b1; spill_op = 1'b0;
    @(posedge clk); #1; spill_req = 1'b0;
    k = 0;
    while (!(mem_req && mem_we) && k < 50) begin @(posedge clk); #1; k++; end
    chk("swr_reached", mem_req && mem_we, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    bfs_rst_n = 1'b0; #1;
    chk("rst_drops_mem_req", mem_req, 1'b0);
    chk("rst_clears_flags", {overflow, underflow}, 2'b00);
    chk("rst_ring_empty2", ring_empty, 1'b1);
    ring_q.delete(); exp_wr.delete(); exp_rd.delete(); exp_beats.delete(); wr_log.delete();
    mhead = 0; mtail = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    bfs_rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    gnt_delay = 2;
    do_spill(64'hF00D_0000_0000_0000, 64'h9);
    chk("post_reset_addr", wr_log[0], 32'h1000_0000);
    do_restore(n);

    chk("exp_beats_drained", exp_beats.size(), 0);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
